// File: rtl/alu_disp_scan.sv
// rtl/alu_disp_scan.sv - ALU result snapshot and LED page sequencer
//
// Captures the ALU result word and flags on a capture strobe and drives the
// page select of the 8-LED result mux. Pages 0..3 show bytes 0..3 of the
// snapshot, page 4 shows the flags. Auto mode steps through the pages on a
// fixed dwell period; manual mode steps one page per debounced button press.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   F, ZF, OF    live ALU result word, zero flag, overflow flag
//   capture      level; snapshot F/ZF/OF on every edge it is high
//   auto_en      1 = timed auto scan, 0 = manual stepping
//   hold         freezes page and dwell counter, drops button steps
//   step_btn     raw asynchronous push-button, active-high
//   F_LED_SW     page select to the LED mux (0..4)
//   F_snap       registered snapshot of F
//   ZF_snap      registered snapshot of ZF
//   OF_snap      registered snapshot of OF
//   page_tick    one-cycle pulse in the first cycle a new page is shown

module alu_disp_scan #(
  parameter int DWELL = 50_000_000,
  parameter int DEB   = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] F,
  input  logic        ZF,
  input  logic        OF,
  input  logic        capture,
  input  logic        auto_en,
  input  logic        hold,
  input  logic        step_btn,
  output logic [2:0]  F_LED_SW,
  output logic [31:0] F_snap,
  output logic        ZF_snap,
  output logic        OF_snap,
  output logic        page_tick
);

  localparam int DWW = $clog2(DWELL);
  localparam int DBW = $clog2(DEB);
  localparam logic [DWW-1:0] DWELL_LAST = DWW'(DWELL - 1);
  localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEB - 1);
  localparam logic [2:0]     LAST_PAGE  = 3'd4;

  // Button path: two-flop synchroniser followed by a hold-time debouncer.
  logic           btn_meta;
  logic           btn_sync;
  logic           btn_stable;
  logic [DBW-1:0] deb_cnt;
  logic           deb_last;
  logic           step;

  assign deb_last = (deb_cnt == DEB_LAST);
  // Only the accepted 0->1 transition produces a step; release is silent.
  assign step     = btn_sync & ~btn_stable & deb_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta   <= 1'b0;
      btn_sync   <= 1'b0;
      btn_stable <= 1'b0;
      deb_cnt    <= '0;
    end else begin
      btn_meta <= step_btn;
      btn_sync <= btn_meta;
      if (btn_sync != btn_stable) begin
        if (deb_last) begin
          btn_stable <= btn_sync;
          deb_cnt    <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // Page sequencing and dwell timing.
  logic [DWW-1:0] dwell_cnt;
  logic [DWW-1:0] dwell_eff;
  logic [DWW-1:0] dwell_nxt;
  logic           auto_q;
  logic           auto_nxt;
  logic [2:0]     page_nxt;
  logic           tick_nxt;
  logic           advance;

  // auto_q remembers the mode seen on the last edge that was not held, so a
  // fresh entry into auto mode counts from zero even if the counter was left
  // non-zero by an earlier held auto period.
  assign dwell_eff = auto_q ? dwell_cnt : '0;

  always_comb begin
    advance   = 1'b0;
    dwell_nxt = dwell_cnt;
    auto_nxt  = auto_q;
    page_nxt  = F_LED_SW;
    tick_nxt  = 1'b0;

    if (capture) begin
      dwell_nxt = '0;
      auto_nxt  = auto_en;
      page_nxt  = 3'd0;
    end else if (!hold) begin
      auto_nxt = auto_en;
      if (auto_en) begin
        // Expiry and a step on the same edge merge into one advance.
        if ((dwell_eff == DWELL_LAST) || step) begin
          advance   = 1'b1;
          dwell_nxt = '0;
        end else begin
          dwell_nxt = dwell_eff + 1'b1;
        end
      end else begin
        dwell_nxt = '0;
        advance   = step;
      end
    end

    if (advance) begin
      page_nxt = (F_LED_SW == LAST_PAGE) ? 3'd0 : F_LED_SW + 3'd1;
      tick_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      F_LED_SW  <= 3'd0;
      dwell_cnt <= '0;
      auto_q    <= 1'b0;
      page_tick <= 1'b0;
    end else begin
      F_LED_SW  <= page_nxt;
      dwell_cnt <= dwell_nxt;
      auto_q    <= auto_nxt;
      page_tick <= tick_nxt;
    end
  end

  // Snapshot registers keep the display steady while the ALU inputs move.
  always_ff @(posedge clk) begin
    if (rst) begin
      F_snap  <= 32'd0;
      ZF_snap <= 1'b0;
      OF_snap <= 1'b0;
    end else if (capture) begin
      F_snap  <= F;
      ZF_snap <= ZF;
      OF_snap <= OF;
    end
  end

endmodule

// File: tb/tb_alu_disp_scan.sv
// tb/tb_alu_disp_scan.sv - self-checking bench for alu_disp_scan

module tb_alu_disp_scan;

  localparam int DWELL = 8;
  localparam int DEB   = 4;

  logic        clk;
  logic        rst;
  logic [31:0] F;
  logic        ZF;
  logic        OF;
  logic        capture;
  logic        auto_en;
  logic        hold;
  logic        step_btn;
  logic [2:0]  F_LED_SW;
  logic [31:0] F_snap;
  logic        ZF_snap;
  logic        OF_snap;
  logic        page_tick;

  alu_disp_scan #(.DWELL(DWELL), .DEB(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .F         (F),
    .ZF        (ZF),
    .OF        (OF),
    .capture   (capture),
    .auto_en   (auto_en),
    .hold      (hold),
    .step_btn  (step_btn),
    .F_LED_SW  (F_LED_SW),
    .F_snap    (F_snap),
    .ZF_snap   (ZF_snap),
    .OF_snap   (OF_snap),
    .page_tick (page_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: button history as sample queues, dwell as elapsed
  // cycles since the last restart, page as a modulo-5 integer.
  int          m_page;
  int          m_elapsed;
  bit          m_auto_seen;
  bit          m_stable;
  bit          m_tick;
  logic [31:0] m_fsnap;
  bit          m_zf;
  bit          m_of;
  bit          raw_q[$];
  bit          sync_q[$];

  function automatic void model_reset();
    m_page      = 0;
    m_elapsed   = 0;
    m_auto_seen = 0;
    m_stable    = 0;
    m_tick      = 0;
    m_fsnap     = 32'd0;
    m_zf        = 0;
    m_of        = 0;
    raw_q.delete();
    sync_q.delete();
  endfunction

  function automatic void model_advance();
    m_page = (m_page + 1) % 5;
    m_tick = 1;
  endfunction

  function automatic void model_edge();
    bit sync_now;
    bit step_m;
    bit all_diff;
    int n;
    if (rst) begin
      model_reset();
      return;
    end
    // The synchronised level at this edge is the raw level from two edges ago.
    n = raw_q.size();
    sync_now = (n >= 2) ? raw_q[n-2] : 1'b0;
    raw_q.push_back(step_btn);
    if (raw_q.size() > 4) void'(raw_q.pop_front());
    // A new level is accepted after DEB consecutive differing samples.
    sync_q.push_back(sync_now);
    if (sync_q.size() > DEB) void'(sync_q.pop_front());
    step_m = 0;
    if (sync_q.size() == DEB) begin
      all_diff = 1;
      foreach (sync_q[i]) if (sync_q[i] == m_stable) all_diff = 0;
      if (all_diff) begin
        m_stable = ~m_stable;
        step_m   = m_stable;
        sync_q.delete();
      end
    end
    m_tick = 0;
    if (capture) begin
      m_fsnap     = F;
      m_zf        = ZF;
      m_of        = OF;
      m_page      = 0;
      m_elapsed   = 0;
      m_auto_seen = auto_en;
    end else if (!hold) begin
      if (auto_en) begin
        if (!m_auto_seen) m_elapsed = 0;
        m_elapsed++;
        if (m_elapsed == DWELL || step_m) begin
          model_advance();
          m_elapsed = 0;
        end
      end else begin
        m_elapsed = 0;
        if (step_m) model_advance();
      end
      m_auto_seen = auto_en;
    end
  endfunction

  task automatic check_model();
    checks++;
    if (F_LED_SW !== 3'(m_page) || page_tick !== m_tick || F_snap !== m_fsnap ||
        ZF_snap !== m_zf || OF_snap !== m_of) begin
      errors++;
      $display("FAIL model t=%0t: got page=%0d tick=%0b F=%h Z=%0b O=%0b, want page=%0d tick=%0b F=%h Z=%0b O=%0b",
               $time, F_LED_SW, page_tick, F_snap, ZF_snap, OF_snap,
               m_page, m_tick, m_fsnap, m_zf, m_of);
    end
  endtask

  task automatic checkv(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  // One clock edge: model and DUT see the same inputs, outputs sampled 1 later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    bit          rst;
    bit          cap;
    bit          aut;
    bit          hld;
    bit          btn;
    logic [31:0] f;
    bit          zf;
    bit          ofl;
    int          page;
    bit          tck;
    logic [31:0] fsnap;
    bit          zs;
    bit          os;
  } vec_t;

  vec_t vt[$];

  function automatic void add(bit r, bit c, bit a, bit h, bit b, logic [31:0] f,
                              bit z, bit o, int pg, bit tk, logic [31:0] fs,
                              bit zs, bit os);
    vec_t v;
    v.rst = r; v.cap = c; v.aut = a; v.hld = h; v.btn = b;
    v.f = f; v.zf = z; v.ofl = o;
    v.page = pg; v.tck = tk; v.fsnap = fs; v.zs = zs; v.os = os;
    vt.push_back(v);
  endfunction

  initial begin
    bit bp[20];
    int pulses;
    int maxpage;
    int btn_run;

    rst = 1'b1; capture = 1'b0; auto_en = 1'b0; hold = 1'b0;
    step_btn = 1'b0; F = 32'd0; ZF = 1'b0; OF = 1'b0;
    model_reset();

    // Reset and capture vectors.
    add(1, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0, 0);
    add(1, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0, 0);
    add(0, 1, 0, 0, 0, 32'h1234_5678,  0, 1, 0, 0, 32'h1234_5678,  0, 1);
    add(0, 0, 0, 0, 0, 32'hFFFF_FFFF,  1, 0, 0, 0, 32'h1234_5678,  0, 1);
    add(0, 1, 0, 0, 0, 32'hFFFF_FFFF,  1, 0, 0, 0, 32'hFFFF_FFFF,  1, 0);
    add(0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'hFFFF_FFFF,  1, 0);
    // Manual debounce: bounce 1,0,1,0 then steady high from row 4, release at row 12.
    bp = '{1, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 20; i++)
      add(0, 0, 0, 0, bp[i], 32'h0, 0, 0, (i >= 9) ? 1 : 0, (i == 9),
          32'hFFFF_FFFF, 1, 0);

    foreach (vt[i]) begin
      rst = vt[i].rst; capture = vt[i].cap; auto_en = vt[i].aut;
      hold = vt[i].hld; step_btn = vt[i].btn;
      F = vt[i].f; ZF = vt[i].zf; OF = vt[i].ofl;
      tick();
      checks++;
      if (F_LED_SW !== 3'(vt[i].page) || page_tick !== vt[i].tck ||
          F_snap !== vt[i].fsnap || ZF_snap !== vt[i].zs || OF_snap !== vt[i].os) begin
        errors++;
        $display("FAIL vec[%0d]: got page=%0d tick=%0b F=%h Z=%0b O=%0b, want page=%0d tick=%0b F=%h Z=%0b O=%0b",
                 i, F_LED_SW, page_tick, F_snap, ZF_snap, OF_snap,
                 vt[i].page, vt[i].tck, vt[i].fsnap, vt[i].zs, vt[i].os);
      end
    end
    capture = 1'b0; step_btn = 1'b0; F = 32'd0; ZF = 1'b0; OF = 1'b0;

    // Auto scan: pages change every DWELL edges, five pulses in 47 edges.
    do_reset();
    auto_en = 1'b1;
    pulses  = 0;
    maxpage = 0;
    for (int k = 1; k <= 47; k++) begin
      tick();
      if (page_tick) pulses++;
      if (int'(F_LED_SW) > maxpage) maxpage = int'(F_LED_SW);
      checkv("auto_page", F_LED_SW, (k / DWELL) % 5);
      checkv("auto_tick", page_tick, (k % DWELL) == 0);
    end
    checkv("auto_pulses", pulses, 5);
    checkv("auto_maxpage", maxpage, 4);

    // Hold: frozen page, press discarded, remaining dwell resumes afterwards.
    do_reset();
    auto_en = 1'b1;
    repeat (3) tick();
    hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step_btn = (i >= 1 && i < 9);
      tick();
      checkv("hold_page", F_LED_SW, 0);
      checkv("hold_tick", page_tick, 0);
    end
    hold = 1'b0;
    step_btn = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      tick();
      checkv("unhold_page", F_LED_SW, (i < 5) ? 0 : ((i < 13) ? 1 : 2));
      checkv("unhold_tick", page_tick, (i == 5) || (i == 13));
    end

    // Collision: step on the dwell-expiry edge, then capture on an advance edge.
    do_reset();
    auto_en = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      step_btn = (e >= 3 && e < 11);
      capture  = (e == 24);
      F        = (e == 24) ? 32'hA5C3_0F96 : $urandom;
      ZF       = (e == 24);
      OF       = 1'b0;
      tick();
      if (e == 8)  begin checkv("coll_page", F_LED_SW, 1); checkv("coll_tick", page_tick, 1); end
      if (e == 15) checkv("coll_hold_page", F_LED_SW, 1);
      if (e == 16) checkv("coll_restart_page", F_LED_SW, 2);
      if (e == 24) begin
        checkv("cap_page", F_LED_SW, 0);
        checkv("cap_tick", page_tick, 0);
        checkv("cap_fsnap", F_snap, 32'hA5C3_0F96);
      end
      if (e == 31) checkv("cap_dwell_page", F_LED_SW, 0);
      if (e == 32) begin checkv("cap_next_page", F_LED_SW, 1); checkv("cap_next_tick", page_tick, 1); end
    end
    capture = 1'b0;
    step_btn = 1'b0;

    // Reset mid-operation with page 3 and a press two counts into debounce.
    do_reset();
    auto_en = 1'b1;
    for (int e = 1; e <= 26; e++) begin
      step_btn = (e >= 23);
      tick();
    end
    checkv("mid_page", F_LED_SW, 3);
    rst = 1'b1;
    tick();
    checkv("rst_page", F_LED_SW, 0);
    checkv("rst_tick", page_tick, 0);
    checkv("rst_fsnap", F_snap, 0);
    checkv("rst_flags", {ZF_snap, OF_snap}, 0);
    rst = 1'b0;
    step_btn = 1'b0;
    for (int r = 1; r <= 8; r++) begin
      tick();
      checkv("post_rst_page", F_LED_SW, (r == 8) ? 1 : 0);
      checkv("post_rst_tick", page_tick, r == 8);
    end

    // Randomised stimulus against the model.
    btn_run = 0;
    for (int n = 0; n < 4000; n++) begin
      rst     = ($urandom_range(0, 199) == 0);
      capture = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 59) == 0)  hold    = ~hold;
      if ($urandom_range(0, 299) == 0) auto_en = ~auto_en;
      if (btn_run == 0) begin
        step_btn = $urandom_range(0, 1);
        btn_run  = $urandom_range(1, 12);
      end
      btn_run--;
      F  = $urandom;
      ZF = $urandom_range(0, 1);
      OF = $urandom_range(0, 1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
